// File: rtl/mac_seq_pkg.sv
// Shared types and widths for the MAC operand sequencer.
package mac_seq_pkg;

  localparam int OP_W  = 4;
  localparam int ACC_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
    logic            cin;
  } mac_op_t;

endpackage

// File: rtl/mac_op_fifo.sv
// Synchronous operand FIFO; pointers carry one extra bit so full and empty
// are told apart when the index bits match.
module mac_op_fifo
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  mac_op_t din,
  input  logic    pop,
  output mac_op_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  mac_op_t       mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot the push lands in
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Operand sequencer for the 4-bit MAC: clears the accumulator, issues len
// queued (a,b,cin) triples, drains the MAC pipe and returns {sum, carry}.
// Build option MAC_SEQ_OVF_STICKY_EN: m_ovf is the OR of cout over the frame.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [OP_W-1:0]  s_a,
  input  logic [OP_W-1:0]  s_b,
  input  logic             s_cin,
  output logic [OP_W-1:0]  mac_a,
  output logic [OP_W-1:0]  mac_b,
  output logic             mac_cin,
  output logic             mac_clr,
  input  logic [ACC_W-1:0] mac_result,
  input  logic             mac_cout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [ACC_W-1:0] m_sum,
  output logic             m_ovf,
  output logic             busy
);

  // DRAIN spans the cycle showing the last operand plus MAC_LAT+1 zero cycles
  localparam int STAGES = MAC_LAT + 1;

  seq_state_t      state;
  logic [7:0]      cnt;
  logic [STAGES:0] vld_pipe;
  mac_op_t         push_op, head;
  logic            full, empty, pop, ovf_cap;

  assign push_op = '{a: s_a, b: s_b, cin: s_cin};
  assign s_ready = !full;
  assign pop     = (state == RUN) && !empty && (cnt != 8'd0);
  assign busy    = (state != IDLE);

  mac_op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s_valid & s_ready),
    .din   (push_op),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

`ifdef MAC_SEQ_OVF_STICKY_EN
  logic ovf_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              ovf_acc <= 1'b0;
    else if (state == CLEAR)               ovf_acc <= mac_cout;
    else if (state == RUN || state == DRAIN) ovf_acc <= ovf_acc | mac_cout;
  end

  assign ovf_cap = ovf_acc | mac_cout;
`else
  assign ovf_cap = mac_cout;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      vld_pipe <= '0;
      mac_a    <= '0;
      mac_b    <= '0;
      mac_cin  <= 1'b0;
      mac_clr  <= 1'b1;
      m_valid  <= 1'b0;
      m_sum    <= '0;
      m_ovf    <= 1'b0;
    end else begin
      // the MAC adds every edge, so anything but a pop feeds it 0*0+0
      mac_a   <= '0;
      mac_b   <= '0;
      mac_cin <= 1'b0;
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= len;
            mac_clr <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          vld_pipe <= {{STAGES{1'b0}}, 1'b1};
          state    <= (cnt == 8'd0) ? DRAIN : RUN;
        end
        RUN: begin
          if (pop) begin
            mac_a   <= head.a;
            mac_b   <= head.b;
            mac_cin <= head.cin;
            cnt     <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              vld_pipe <= {{STAGES{1'b0}}, 1'b1};
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (vld_pipe[STAGES]) begin
            m_sum   <= mac_result;
            m_ovf   <= ovf_cap;
            m_valid <= 1'b1;
            state   <= DONE;
          end else begin
            vld_pipe <= vld_pipe << 1;
          end
        end
        DONE: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
